requant_out: RTL and testbench

Downstream stage of the matrix core. Accepts the MAT_DIM accumulator results of each matrix-vector product over a valid/ready stream. Per result it:

- adds a per-row bias,
- applies a rounding right shift,
- saturates to DATA_WIDTH.

Results leave on a DATA_WIDTH valid/ready stream with an end-of-vector flag. A two-stage elastic pipeline sustains one result per cycle and absorbs back-pressure without loss.

---
 rtl/requant_out.sv | 101 ++++++++++
 tb/tb_requant_out.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_out.sv
// Requantization stage: per-row bias add, rounding right shift and saturation
// of accumulator results, behind a two-stage elastic valid/ready pipeline.
module requant_out #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int MAT_DIM    = 4,
  localparam int RW        = $clog2(MAT_DIM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  snk_vld,
  output logic                  snk_rdy,
  input  logic [ACC_WIDTH-1:0]  snk_data,
  output logic                  src_vld,
  input  logic                  src_rdy,
  output logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_last,
  input  logic                  cfg_wr,
  input  logic [RW-1:0]         cfg_addr,
  input  logic [ACC_WIDTH-1:0]  cfg_bias,
  input  logic [4:0]            cfg_shift,
  output logic [7:0]            sat_cnt
);

  localparam int SW = ACC_WIDTH + 2;
  localparam logic [RW-1:0] LAST_ROW = RW'(MAT_DIM - 1);

  logic [ACC_WIDTH-1:0] bias [MAT_DIM];
  logic [RW-1:0]        row;
  logic                 a_vld;
  logic [SW-1:0]        a_sum;
  logic                 a_last;
  logic                 b_vld;

  logic                 b_adv;
  logic                 a_adv;
  logic                 snk_acc;
  logic [SW-1:0]        round_v;
  logic [SW-1:0]        sum_w;
  logic [SW-1:0]        q_w;
  logic                 sat_w;

  always_comb begin
    b_adv   = !b_vld || src_rdy;
    a_adv   = a_vld && b_adv;
    snk_rdy = !a_vld || b_adv;
    snk_acc = snk_vld && snk_rdy;

    round_v = '0;
    if (cfg_shift != 5'd0)
      round_v = SW'(1) << (cfg_shift - 5'd1);
    sum_w = SW'(snk_data) + SW'(bias[row]) + round_v;

    q_w   = a_sum >> cfg_shift;
    sat_w = |q_w[SW-1:DATA_WIDTH];
  end

  // Stage A, row tracking and bias table; bias is read before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAT_DIM; i++)
        bias[i] <= '0;
      row    <= '0;
      a_vld  <= 1'b0;
      a_sum  <= '0;
      a_last <= 1'b0;
    end else begin
      if (cfg_wr)
        bias[cfg_addr] <= cfg_bias;
      if (snk_acc) begin
        a_vld  <= 1'b1;
        a_sum  <= sum_w;
        a_last <= (row == LAST_ROW);
        row    <= (row == LAST_ROW) ? '0 : row + RW'(1);
      end else if (a_adv) begin
        a_vld <= 1'b0;
      end
    end
  end

  // Stage B holds the output beat; data and last only change when A moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld    <= 1'b0;
      src_data <= '0;
      src_last <= 1'b0;
      sat_cnt  <= '0;
    end else if (b_adv) begin
      b_vld <= a_vld;
      if (a_vld) begin
        src_data <= sat_w ? '1 : q_w[DATA_WIDTH-1:0];
        src_last <= a_last;
        if (sat_w && sat_cnt != '1)
          sat_cnt <= sat_cnt + 8'd1;
      end
    end
  end

  assign src_vld = b_vld;

endmodule

// File: tb/tb_requant_out.sv
// Bench for requant_out: directed cases plus randomized traffic against an
// arithmetic reference model of bias/round/shift/saturate and row order.
module tb_requant_out;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int MD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          snk_vld;
  logic          snk_rdy;
  logic [AW-1:0] snk_data;
  logic          src_vld;
  logic          src_rdy;
  logic [DW-1:0] src_data;
  logic          src_last;
  logic          cfg_wr;
  logic [1:0]    cfg_addr;
  logic [AW-1:0] cfg_bias;
  logic [4:0]    cfg_shift;
  logic [7:0]    sat_cnt;

  requant_out #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAT_DIM(MD)) dut (
    .clk(clk), .rst_n(rst_n),
    .snk_vld(snk_vld), .snk_rdy(snk_rdy), .snk_data(snk_data),
    .src_vld(src_vld), .src_rdy(src_rdy), .src_data(src_data), .src_last(src_last),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_bias(cfg_bias), .cfg_shift(cfg_shift),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  int     n_acc   = 0;
  bit     chk_lat = 1'b0;

  longint mbias [MD];
  int     mrow    = 0;
  int     exp_sat = 0;
  int     exp_d[$];
  int     exp_l[$];
  int     exp_c[$];
  int     got_d[$];
  int     got_l[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: ((acc + bias) + half-LSB) / 2^shift, clamped to the output range.
  function automatic longint ref_q(input longint acc, input longint b, input int sh);
    longint v;
    v = acc + b;
    if (sh != 0) v = v + (longint'(1) << (sh - 1));
    return v >> sh;
  endfunction

  // One clock: evaluate handshakes mid-low-phase, update model, advance to next negedge.
  task automatic cycle();
    longint q;
    int     d, l, c;
    #1;
    if (snk_vld && snk_rdy) begin
      q = ref_q(longint'(snk_data), mbias[mrow], int'(cfg_shift));
      if (q > 255) begin
        exp_d.push_back(255);
        if (exp_sat < 255) exp_sat++;
      end else begin
        exp_d.push_back(int'(q));
      end
      exp_l.push_back(mrow == MD - 1 ? 1 : 0);
      exp_c.push_back(cyc);
      mrow = (mrow + 1) % MD;
      n_acc++;
    end
    if (cfg_wr) mbias[cfg_addr] = longint'(cfg_bias);
    if (src_vld && src_rdy) begin
      if (exp_d.size() == 0) begin
        check("spurious_beat", 1, 0);
      end else begin
        d = exp_d.pop_front();
        l = exp_l.pop_front();
        c = exp_c.pop_front();
        check("data", src_data, d);
        check("last", src_last, l);
        if (chk_lat) check("latency", cyc - c, 2);
      end
      got_d.push_back(int'(src_data));
      got_l.push_back(int'(src_last));
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int data);
    int start;
    start    = n_acc;
    snk_vld  = 1'b1;
    snk_data = AW'(data);
    for (int i = 0; i < 50 && n_acc == start; i++) cycle();
    if (n_acc == start) check("send_timeout", 0, 1);
    snk_vld = 1'b0;
  endtask

  task automatic drain();
    snk_vld = 1'b0;
    src_rdy = 1'b1;
    for (int i = 0; i < 20 && exp_d.size() > 0; i++) cycle();
    check("drain_left", exp_d.size(), 0);
    cycle();
  endtask

  task automatic write_bias(input int r, input int b);
    cfg_wr   = 1'b1;
    cfg_addr = 2'(r);
    cfg_bias = AW'(b);
    cycle();
    cfg_wr   = 1'b0;
  endtask

  int bp[4];
  int acc0;

  initial begin
    rst_n = 1'b0; snk_vld = 1'b0; snk_data = '0; src_rdy = 1'b0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_shift = '0;
    for (int i = 0; i < MD; i++) mbias[i] = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_snk_rdy", snk_rdy, 1);
    check("rst_src_vld", src_vld, 0);
    check("rst_src_data", src_data, 0);
    check("rst_src_last", src_last, 0);
    check("rst_sat_cnt", sat_cnt, 0);

    // pass-through, back-to-back, latency two edges
    src_rdy = 1'b1; chk_lat = 1'b1; got_d.delete(); got_l.delete();
    snk_vld = 1'b1;
    foreach (bp[i]) bp[i] = 0;
    bp[0] = 100; bp[1] = 0; bp[2] = 255; bp[3] = 7;
    for (int i = 0; i < 4; i++) begin
      snk_data = AW'(bp[i]);
      check("pt_snk_rdy", snk_rdy, 1);
      cycle();
    end
    drain();
    chk_lat = 1'b0;
    check("pt_count", got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      check("pt_val", got_d[i], bp[i]);
      check("pt_last", got_l[i], i == 3 ? 1 : 0);
    end

    // bias by row, two vectors
    write_bias(2, 10);
    for (int v = 0; v < 2; v++) begin
      got_d.delete(); got_l.delete();
      for (int i = 1; i <= 4; i++) send(i);
      drain();
      check("bias_count", got_d.size(), 4);
      if (got_d.size() == 4) begin
        check("bias_r2", got_d[2], 13);
        check("bias_r3", got_d[3], 4);
        check("bias_last", got_l[3], 1);
      end
    end
    write_bias(2, 0);

    // rounding
    got_d.delete();
    cfg_shift = 5'd1;
    send(383); send(382);
    drain();
    cfg_shift = 5'd4;
    send(12'h7F8);
    drain();
    check("rnd_count", got_d.size(), 3);
    if (got_d.size() == 3) begin
      check("rnd_383", got_d[0], 192);
      check("rnd_382", got_d[1], 191);
      check("rnd_7f8", got_d[2], 128);
    end

    // saturation and sticky counter
    cfg_shift = 5'd0;
    got_d.delete();
    send(300);
    drain();
    if (got_d.size() > 0) check("sat_val", got_d[0], 255);
    check("sat_cnt_1", sat_cnt, 1);
    snk_vld = 1'b1; snk_data = AW'(1000);
    for (int i = 0; i < 300 && n_acc < 0 + 1_000_000; i++) begin
      if (exp_sat >= 255 && exp_c.size() == 0) break;
      cycle();
      if (i >= 255) break;
    end
    drain();
    check("sat_cnt_sticky", sat_cnt, 255);

    // back-pressure fill and release
    bp[0] = 11; bp[1] = 22; bp[2] = 33; bp[3] = 44;
    got_d.delete();
    src_rdy = 1'b0;
    acc0 = n_acc;
    snk_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      snk_data = AW'(bp[n_acc - acc0]);
      cycle();
    end
    check("bp_accepted", n_acc - acc0, 2);
    check("bp_snk_rdy_low", snk_rdy, 0);
    src_rdy = 1'b1;
    #1;
    check("bp_release_rdy", snk_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      if (n_acc - acc0 < 4) begin
        snk_vld = 1'b1;
        snk_data = AW'(bp[n_acc - acc0]);
      end else begin
        snk_vld = 1'b0;
      end
      check("bp_no_gap", src_vld, 1);
      cycle();
    end
    drain();
    check("bp_count", got_d.size(), 4);

    // reset mid-vector
    src_rdy = 1'b0;
    send(5); send(6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_src_vld", src_vld, 0);
    check("mid_rst_src_data", src_data, 0);
    check("mid_rst_src_last", src_last, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    check("mid_rst_snk_rdy", snk_rdy, 1);
    exp_d.delete(); exp_l.delete(); exp_c.delete();
    mrow = 0; exp_sat = 0;
    for (int i = 0; i < MD; i++) mbias[i] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    src_rdy = 1'b1;
    got_d.delete(); got_l.delete();
    for (int i = 0; i < 4; i++) send(50 + i);
    drain();
    check("mid_rst_count", got_l.size(), 4);
    if (got_l.size() == 4) begin
      check("mid_rst_last3", got_l[3], 1);
      check("mid_rst_last2", got_l[2], 0);
    end

    // randomized traffic, shift changed only with the pipeline empty
    for (int blk = 0; blk < 10; blk++) begin
      cfg_shift = 5'($urandom_range(0, 20));
      for (int i = 0; i < 200; i++) begin
        snk_vld  = ($urandom_range(0, 3) != 0);
        src_rdy  = ($urandom_range(0, 2) != 0);
        snk_data = AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 600) : $urandom);
        cfg_wr   = ($urandom_range(0, 15) == 0);
        cfg_addr = 2'($urandom);
        cfg_bias = AW'($urandom_range(0, 4095));
        cycle();
      end
      cfg_wr = 1'b0;
      drain();
      check("rnd_sat_cnt", sat_cnt, exp_sat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
